// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor: holds the PLL in reset, waits for lock with a bounded
// number of timed-out attempts, and releases the core reset once lock has
// been stable. Re-runs the sequence on loss of lock or on a restart request.
module pll_lock_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       core_reset,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_HOLD_RESET = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  // Terminal counts of the shared cycle counter for each timed state.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  logic             sync_meta_reg;
  logic             lock_s_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       retry_reg, retry_next;
  logic [7:0]       loss_reg, loss_next;
  logic             pll_resetb_reg, pll_resetb_next;
  logic             core_reset_reg, core_reset_next;
  logic             locked_reg, locked_next;
  logic             fail_reg, fail_next;

  // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      sync_meta_reg <= pll_lock;
      lock_s_reg    <= sync_meta_reg;
    end
  end

  // Next-state, counter and event bookkeeping; outputs decoded from the next
  // state so the registered outputs change on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    loss_next  = loss_reg;
    if (restart) begin
      state_next = ST_HOLD_RESET;
      cnt_next   = '0;
      retry_next = 3'd0;
    end else begin
      case (state_reg)
        ST_HOLD_RESET: begin
          if (cnt_reg == HOLD_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a timeout that falls on the same cycle.
          if (lock_s_reg) begin
            state_next = ST_STABILIZE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retry_reg == RETRY_LIMIT) begin
              state_next = ST_FAIL;
            end else begin
              retry_next = retry_reg + 3'd1;
              state_next = ST_HOLD_RESET;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_STABILIZE: begin
          // A dropout here gets a fresh timeout window, not a retry.
          if (!lock_s_reg) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            retry_next = 3'd0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s_reg) begin
            state_next = ST_HOLD_RESET;
            cnt_next   = '0;
            if (loss_reg != 8'hFF) begin
              loss_next = loss_reg + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          state_next = ST_FAIL;
        end
        default: begin
          state_next = ST_HOLD_RESET;
          cnt_next   = '0;
        end
      endcase
    end

    pll_resetb_next = !((state_next == ST_HOLD_RESET) || (state_next == ST_FAIL));
    core_reset_next = (state_next != ST_RUN);
    locked_next     = (state_next == ST_RUN);
    fail_next       = (state_next == ST_FAIL);
  end

  // State, counter and registered output updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_HOLD_RESET;
      cnt_reg        <= '0;
      retry_reg      <= 3'd0;
      loss_reg       <= 8'd0;
      pll_resetb_reg <= 1'b0;
      core_reset_reg <= 1'b1;
      locked_reg     <= 1'b0;
      fail_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      loss_reg       <= loss_next;
      pll_resetb_reg <= pll_resetb_next;
      core_reset_reg <= core_reset_next;
      locked_reg     <= locked_next;
      fail_reg       <= fail_next;
    end
  end

  assign pll_resetb      = pll_resetb_reg;
  assign core_reset      = core_reset_reg;
  assign locked          = locked_reg;
  assign fail            = fail_reg;
  assign retry_count     = retry_reg;
  assign lock_loss_count = loss_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: table of {inputs, cycles, expected outputs}
// records applied in order, plus a hand-written lock-loss saturation loop.
// Expected output words are queued when a record is driven and popped and
// compared once its cycles have elapsed.
module tb_pll_lock_sequencer;

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STAB = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FL   = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic       rb;
    logic       cr;
    logic       lk;
    logic       fl;
    logic [2:0] rc;
    logic [7:0] llc;
  } obs_t;

  typedef struct {
    string name;
    logic  rst;
    logic  rs;
    logic  lock;
    int    cyc;
    obs_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       core_reset;
  logic       locked;
  logic       fail;
  logic [2:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_total = 0;
  int n_pass  = 0;

  obs_t  sb_q[$];
  string name_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES  (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .restart        (restart),
    .pll_resetb     (pll_resetb),
    .core_reset     (core_reset),
    .locked         (locked),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  // Build a record; the Moore output levels follow from the expected state.
  function automatic vec_t mk(string n, logic rst, logic rs, logic lock, int cyc,
                              logic [2:0] st, logic [2:0] rc, logic [7:0] llc);
    vec_t v;
    v.name     = n;
    v.rst      = rst;
    v.rs       = rs;
    v.lock     = lock;
    v.cyc      = cyc;
    v.exp.st   = st;
    v.exp.rb   = !(st == S_HOLD || st == S_FL);
    v.exp.cr   = (st != S_RUN);
    v.exp.lk   = (st == S_RUN);
    v.exp.fl   = (st == S_FL);
    v.exp.rc   = rc;
    v.exp.llc  = llc;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check();
    obs_t  e;
    obs_t  a;
    string n;
    e = sb_q.pop_front();
    n = name_q.pop_front();
    a = {state, pll_resetb, core_reset, locked, fail, retry_count, lock_loss_count};
    n_total++;
    if (a === e) begin
      n_pass++;
      $display("ok   %s: st=%0d rb=%0b cr=%0b lk=%0b fl=%0b rc=%0d llc=%0d",
               n, a.st, a.rb, a.cr, a.lk, a.fl, a.rc, a.llc);
    end else begin
      $display("FAIL %s: got st=%0d rb=%0b cr=%0b lk=%0b fl=%0b rc=%0d llc=%0d, expected st=%0d rb=%0b cr=%0b lk=%0b fl=%0b rc=%0d llc=%0d",
               n, a.st, a.rb, a.cr, a.lk, a.fl, a.rc, a.llc,
               e.st, e.rb, e.cr, e.lk, e.fl, e.rc, e.llc);
    end
  endtask

  // Drive a record's inputs (restart only for its first edge), wait its
  // cycles, then compare against the queued expectation.
  task automatic apply(vec_t v);
    reset    = v.rst;
    restart  = v.rs;
    pll_lock = v.lock;
    sb_q.push_back(v.exp);
    name_q.push_back(v.name);
    for (int i = 0; i < v.cyc; i++) begin
      step();
      restart = 1'b0;
    end
    check();
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    reset    = 1'b1;
    restart  = 1'b0;
    pll_lock = 1'b0;

    // Nominal lock, then a single loss of lock in RUN.
    tbl.push_back(mk("rst",          1, 0, 0, 1, S_HOLD, 0, 0));
    tbl.push_back(mk("hold_3",       0, 0, 0, 3, S_HOLD, 0, 0));
    tbl.push_back(mk("hold_done",    0, 0, 0, 1, S_WAIT, 0, 0));
    tbl.push_back(mk("wait_nolock",  0, 0, 0, 9, S_WAIT, 0, 0));
    tbl.push_back(mk("lock_sync",    0, 0, 1, 2, S_WAIT, 0, 0));
    tbl.push_back(mk("stab_enter",   0, 0, 1, 1, S_STAB, 0, 0));
    tbl.push_back(mk("stab_count",   0, 0, 1, 7, S_STAB, 0, 0));
    tbl.push_back(mk("run_enter",    0, 0, 1, 1, S_RUN,  0, 0));
    tbl.push_back(mk("drop_sync",    0, 0, 0, 2, S_RUN,  0, 0));
    tbl.push_back(mk("drop_hold",    0, 0, 0, 1, S_HOLD, 0, 1));
    tbl.push_back(mk("relock_hold",  0, 0, 1, 3, S_HOLD, 0, 1));
    tbl.push_back(mk("relock_wait",  0, 0, 1, 1, S_WAIT, 0, 1));
    tbl.push_back(mk("relock_stab",  0, 0, 1, 1, S_STAB, 0, 1));
    tbl.push_back(mk("relock_count", 0, 0, 1, 7, S_STAB, 0, 1));
    tbl.push_back(mk("relock_run",   0, 0, 1, 1, S_RUN,  0, 1));
    run_table();

    // Repeated 3-cycle lock drops in RUN; count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      int e;
      e = (i + 2 > 255) ? 255 : i + 2;
      apply(mk($sformatf("loss_drop_%0d", i),  0, 0, 0, 3,  S_HOLD, 0, 8'(e)));
      apply(mk($sformatf("loss_relock_%0d", i), 0, 0, 1, 13, S_RUN,  0, 8'(e)));
    end

    // Restart from RUN, then a one-cycle glitch during STABILIZE.
    tbl.push_back(mk("rs_run",      0, 1, 1, 1, S_HOLD, 0, 255));
    tbl.push_back(mk("g_hold",      0, 0, 1, 3, S_HOLD, 0, 255));
    tbl.push_back(mk("g_wait",      0, 0, 1, 1, S_WAIT, 0, 255));
    tbl.push_back(mk("g_stab",      0, 0, 1, 1, S_STAB, 0, 255));
    tbl.push_back(mk("g_stab5",     0, 0, 1, 4, S_STAB, 0, 255));
    tbl.push_back(mk("g_drop",      0, 0, 0, 1, S_STAB, 0, 255));
    tbl.push_back(mk("g_back",      0, 0, 1, 1, S_STAB, 0, 255));
    tbl.push_back(mk("g_rewait",    0, 0, 1, 1, S_WAIT, 0, 255));
    tbl.push_back(mk("g_restab",    0, 0, 1, 1, S_STAB, 0, 255));
    tbl.push_back(mk("g_count",     0, 0, 1, 7, S_STAB, 0, 255));
    tbl.push_back(mk("g_run",       0, 0, 1, 1, S_RUN,  0, 255));
    // Lock never returns: three timed-out attempts end in the failed state.
    tbl.push_back(mk("t_rs",        0, 1, 0, 1,  S_HOLD, 0, 255));
    tbl.push_back(mk("t_hold",      0, 0, 0, 3,  S_HOLD, 0, 255));
    tbl.push_back(mk("t_w0",        0, 0, 0, 1,  S_WAIT, 0, 255));
    tbl.push_back(mk("t_w0_end",    0, 0, 0, 31, S_WAIT, 0, 255));
    tbl.push_back(mk("t_h1",        0, 0, 0, 1,  S_HOLD, 1, 255));
    tbl.push_back(mk("t_h1_end",    0, 0, 0, 3,  S_HOLD, 1, 255));
    tbl.push_back(mk("t_w1",        0, 0, 0, 1,  S_WAIT, 1, 255));
    tbl.push_back(mk("t_w1_end",    0, 0, 0, 31, S_WAIT, 1, 255));
    tbl.push_back(mk("t_h2",        0, 0, 0, 1,  S_HOLD, 2, 255));
    tbl.push_back(mk("t_h2_end",    0, 0, 0, 3,  S_HOLD, 2, 255));
    tbl.push_back(mk("t_w2",        0, 0, 0, 1,  S_WAIT, 2, 255));
    tbl.push_back(mk("t_w2_end",    0, 0, 0, 31, S_WAIT, 2, 255));
    tbl.push_back(mk("t_dead",      0, 0, 0, 1,  S_FL,   2, 255));
    tbl.push_back(mk("t_dead_hold", 0, 0, 0, 50, S_FL,   2, 255));
    // Restart out of the failed state, then restart mid-hold.
    tbl.push_back(mk("rs_dead",     0, 1, 0, 1, S_HOLD, 0, 255));
    tbl.push_back(mk("k_hold",      0, 0, 0, 2, S_HOLD, 0, 255));
    tbl.push_back(mk("rs_hold",     0, 1, 0, 1, S_HOLD, 0, 255));
    tbl.push_back(mk("k_hold2",     0, 0, 0, 3, S_HOLD, 0, 255));
    tbl.push_back(mk("k_wait",      0, 0, 0, 1, S_WAIT, 0, 255));
    // Reset mid-STABILIZE, then reset and restart together.
    tbl.push_back(mk("s_sync",      0, 0, 1, 2,  S_WAIT, 0, 255));
    tbl.push_back(mk("s_stab",      0, 0, 1, 1,  S_STAB, 0, 255));
    tbl.push_back(mk("s_stab2",     0, 0, 1, 2,  S_STAB, 0, 255));
    tbl.push_back(mk("rst_stab",    1, 0, 1, 1,  S_HOLD, 0, 0));
    tbl.push_back(mk("m_hold",      0, 0, 1, 3,  S_HOLD, 0, 0));
    tbl.push_back(mk("m_wait",      0, 0, 1, 1,  S_WAIT, 0, 0));
    tbl.push_back(mk("m_stab",      0, 0, 1, 1,  S_STAB, 0, 0));
    tbl.push_back(mk("m_count",     0, 0, 1, 7,  S_STAB, 0, 0));
    tbl.push_back(mk("m_run",       0, 0, 1, 1,  S_RUN,  0, 0));
    tbl.push_back(mk("m_drop",      0, 0, 0, 3,  S_HOLD, 0, 1));
    tbl.push_back(mk("m_relock",    0, 0, 1, 13, S_RUN,  0, 1));
    tbl.push_back(mk("rst_rs",      1, 1, 1, 1,  S_HOLD, 0, 0));
    tbl.push_back(mk("post_rst",    0, 0, 1, 2,  S_HOLD, 0, 0));
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
